// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment helper for the LSU memory controller
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int MEM_LAT_DEF = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    return (off & ~(3'b111 << size)) != 3'b000;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane shift/mask for stores and shift/extend for loads
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] lane_wdata,
  output logic [7:0]  lane_wmask,
  output logic [63:0] load_data
);
  logic [5:0] sh;
  logic [7:0] bm;
  logic [63:0] rs;
  always_comb begin
    sh = {off, 3'b000};
    bm = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
    lane_wdata = wdata << sh;
    lane_wmask = bm << off;
    rs = rdata >> sh;
    load_data = size == SZ_B ? {{56{~uns & rs[7]}}, rs[7:0]} :
                size == SZ_H ? {{48{~uns & rs[15]}}, rs[15:0]} :
                size == SZ_W ? {{32{~uns & rs[31]}}, rs[31:0]} : rs;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time load/store FSM driving an aligned doubleword memory port
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic        mem_ce,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);
  state_t state;
  logic [7:0] cnt;
  logic we_q, uns_q, acc, st;
  logic [1:0] size_q;
  logic [63:0] addr_q, wdata_q, lane_wdata, load_data;
  logic [7:0] lane_wmask;
  lsu_align u_align (
    .off(addr_q[2:0]),
    .size(size_q),
    .uns(uns_q),
    .wdata(wdata_q),
    .rdata(mem_rdata),
    .lane_wdata(lane_wdata),
    .lane_wmask(lane_wmask),
    .load_data(load_data)
  );
  assign acc = state == ACCESS;
  assign st = acc & we_q;
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP && !rst;
  assign mem_ce = acc;
  assign mem_we = st;
  assign mem_addr = acc ? {addr_q[63:3], 3'b000} : '0;
  assign mem_wdata = st ? lane_wdata : '0;
  assign mem_wmask = st ? lane_wmask : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          uns_q <= req_unsigned;
          size_q <= req_size;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          resp_rdata <= '0;
          resp_err <= misaligned(req_addr[2:0], req_size);
          cnt <= 8'(MEM_LAT - 1);
          state <= misaligned(req_addr[2:0], req_size) ? RESP : ACCESS;
        end
        ACCESS: if (cnt == '0) begin
          resp_rdata <= we_q ? '0 : load_data;
          state <= RESP;
        end else begin
          cnt <= cnt - 8'd1;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
